// File: rtl/instrumented_adder_driver.sv
// Measurement sequencer for the instrumented adder.
// Loads the operands, holds them while the adder settles, then opens the
// ring-oscillator window for a programmed number of cycles. The oscillator's
// rising edges are counted, and the count and the settled sum are reported.
module instrumented_adder_driver #(
   parameter int COUNT_W       = 32,
   parameter int WINDOW_W      = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                start,
   input  logic [31:0]         a_in,
   input  logic [31:0]         b_in,
   input  logic [WINDOW_W-1:0] window,
   input  logic                ring_osc,
   input  logic [31:0]         sum_in,
   output logic [31:0]         a_out,
   output logic [31:0]         b_out,
   output logic                ring_en,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  count_out,
   output logic [31:0]         sum_out,
   output logic                overflow
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_MEASURE = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   // The phase timer is shared by SETTLE and DRAIN, so it must reach the
   // larger of their last-cycle indices.
   localparam int PHASE_MAX = (SETTLE_CYCLES - 1 > SYNC_STAGES) ? (SETTLE_CYCLES - 1) : SYNC_STAGES;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

   localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
   localparam logic [PHASE_W-1:0] DRAIN_LAST  = PHASE_W'(SYNC_STAGES);

   logic [2:0]             state;
   logic [PHASE_W-1:0]     phase;
   logic [WINDOW_W-1:0]    window_left;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_prev;
   logic                   rise;
   logic                   count_en;
   logic                   accept;

   // A new run may only begin from IDLE or DONE; start is ignored while busy.
   assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign rise     = sync_q[SYNC_STAGES-1] && !edge_prev;
   assign count_en = (state == ST_MEASURE) || (state == ST_DRAIN);

   // Status outputs are pure decodes of the state register, so they follow
   // reset and state changes with no extra latency.
   assign ring_en = (state == ST_MEASURE);
   assign busy    = (state == ST_LOAD) || (state == ST_SETTLE) ||
                    (state == ST_MEASURE) || (state == ST_DRAIN);
   assign done    = (state == ST_DONE);

   // Sequencer: operand latch, settle timer, measurement window and drain.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= ST_IDLE;
         phase       <= '0;
         window_left <= '0;
         a_out       <= '0;
         b_out       <= '0;
         sum_out     <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_out       <= a_in;
                  b_out       <= b_in;
                  window_left <= window;
                  sum_out     <= '0;
                  state       <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               phase <= '0;
               state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (phase == SETTLE_LAST) begin
                  sum_out <= sum_in;
                  phase   <= '0;
                  state   <= (window_left != '0) ? ST_MEASURE : ST_DRAIN;
               end else begin
                  phase <= phase + PHASE_W'(1);
               end
            end
            ST_MEASURE: begin
               window_left <= window_left - WINDOW_W'(1);
               if (window_left == WINDOW_W'(1)) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (phase == DRAIN_LAST) begin
                  phase <= '0;
                  state <= ST_DONE;
               end else begin
                  phase <= phase + PHASE_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Bring the asynchronous oscillator tap into the clock domain and keep
   // the previous synchronised value for rising-edge detection.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_q    <= '0;
         edge_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], ring_osc};
         edge_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   // Saturating edge counter with a sticky overflow flag, cleared by a new run.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         count_out <= '0;
         overflow  <= 1'b0;
      end else if (accept) begin
         count_out <= '0;
         overflow  <= 1'b0;
      end else if (count_en && rise) begin
         if (count_out == '1) begin
            overflow <= 1'b1;
         end else begin
            count_out <= count_out + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_instrumented_adder_driver.sv
// Bench for instrumented_adder_driver: two instances (full-width and 3-bit
// counter) share stimulus; a cycle-level reference model of the run timeline
// and of the oscillator waveform is compared against both every cycle.
module tb_instrumented_adder_driver;

   localparam int SETTLE   = 4;
   localparam int SYNC     = 2;
   localparam int WINDOW_W = 16;
   localparam int SMALL_W  = 3;
   localparam int SMALL_MAX = (1 << SMALL_W) - 1;

   logic                wb_clk_i;
   logic                wb_rst_i;
   logic                start;
   logic [31:0]         a_in;
   logic [31:0]         b_in;
   logic [WINDOW_W-1:0] window;
   logic                ring_osc;

   logic [31:0]         sum_in_big, a_out_big, b_out_big, sum_out_big, count_big;
   logic                ring_en_big, busy_big, done_big, ovf_big;

   logic [31:0]         sum_in_small, a_out_small, b_out_small, sum_out_small;
   logic [SMALL_W-1:0]  count_small;
   logic                ring_en_small, busy_small, done_small, ovf_small;

   int vectors;
   int miscompares;

   int cyc;
   bit m_valid;
   bit m_active;
   int m_t0;
   int m_w;
   int m_raw;
   logic [31:0] m_a;
   logic [31:0] m_b;

   int osc_k;
   int ring_hi;

   // The adder itself: a plain combinational sum of the driven operands.
   assign sum_in_big   = a_out_big + b_out_big;
   assign sum_in_small = a_out_small + b_out_small;

   instrumented_adder_driver #(
      .COUNT_W(32), .WINDOW_W(WINDOW_W), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
   ) dut_big (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start),
      .a_in(a_in), .b_in(b_in), .window(window), .ring_osc(ring_osc),
      .sum_in(sum_in_big), .a_out(a_out_big), .b_out(b_out_big),
      .ring_en(ring_en_big), .busy(busy_big), .done(done_big),
      .count_out(count_big), .sum_out(sum_out_big), .overflow(ovf_big)
   );

   instrumented_adder_driver #(
      .COUNT_W(SMALL_W), .WINDOW_W(WINDOW_W), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
   ) dut_small (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start),
      .a_in(a_in), .b_in(b_in), .window(window), .ring_osc(ring_osc),
      .sum_in(sum_in_small), .a_out(a_out_small), .b_out(b_out_small),
      .ring_en(ring_en_small), .busy(busy_small), .done(done_small),
      .count_out(count_small), .sum_out(sum_out_small), .overflow(ovf_small)
   );

   // Free-running clock.
   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   // Relative cycle at which DONE is first reached after an accepted start
   // (LOAD is relative cycle 1).
   function automatic int done_rel(input int w);
      return 2 + SETTLE + w + SYNC + 1;
   endfunction

   // Number of rising edges of the 3-low/3-high oscillator over w cycles.
   function automatic int edges_in_window(input int w);
      int n;
      bit prev;
      bit v;
      n = 0;
      prev = 1'b0;
      for (int k = 0; k < w; k++) begin
         v = ((k / 3) % 2) == 1;
         if (v && !prev) n++;
         prev = v;
      end
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   // Oscillator model: toggles 3 low / 3 high while the ring is enabled.
   initial begin
      ring_osc = 1'b0;
      osc_k = 0;
      forever begin
         @(posedge wb_clk_i);
         #1;
         if (ring_en_big) begin
            ring_osc = ((osc_k / 3) % 2) == 1;
            osc_k++;
         end else begin
            ring_osc = 1'b0;
            osc_k = 0;
         end
      end
   end

   // Reference model: tracks reset, run acceptance and the run timeline.
   initial begin
      int cur_rel;
      cyc = 0;
      m_valid = 1'b0;
      m_active = 1'b0;
      m_t0 = 0;
      m_w = 0;
      m_raw = 0;
      m_a = '0;
      m_b = '0;
      forever begin
         @(posedge wb_clk_i);
         cur_rel = cyc - m_t0 + 1;
         cyc++;
         if (wb_rst_i) begin
            m_valid = 1'b1;
            m_active = 1'b0;
            m_a = '0;
            m_b = '0;
            m_w = 0;
            m_raw = 0;
         end else if (m_valid && start && (!m_active || cur_rel >= done_rel(m_w))) begin
            m_active = 1'b1;
            m_t0 = cyc;
            m_a = a_in;
            m_b = b_in;
            m_w = int'(window);
            m_raw = edges_in_window(m_w);
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   initial begin
      int rel;
      bit e_busy, e_done, e_ring, e_zero;
      logic [31:0] e_sum;
      int e_cnt_small;
      forever begin
         @(negedge wb_clk_i);
         if (m_valid) begin
            rel = cyc - m_t0 + 1;
            e_busy = m_active && (rel < done_rel(m_w));
            e_done = m_active && (rel >= done_rel(m_w));
            e_ring = m_active && (rel >= 2 + SETTLE) && (rel <= 1 + SETTLE + m_w);
            e_zero = !m_active || (rel <= 1 + SETTLE);
            e_sum  = m_a + m_b;
            e_cnt_small = (m_raw > SMALL_MAX) ? SMALL_MAX : m_raw;

            checkOutput("busy", 32'(busy_big), 32'(e_busy));
            checkOutput("done", 32'(done_big), 32'(e_done));
            checkOutput("ring_en", 32'(ring_en_big), 32'(e_ring));
            checkOutput("a_out", a_out_big, m_a);
            checkOutput("b_out", b_out_big, m_b);
            checkOutput("busy_small", 32'(busy_small), 32'(e_busy));
            checkOutput("done_small", 32'(done_small), 32'(e_done));
            checkOutput("ring_en_small", 32'(ring_en_small), 32'(e_ring));
            checkOutput("a_out_small", a_out_small, m_a);
            if (e_zero) begin
               checkOutput("count_clear", count_big, 32'd0);
               checkOutput("sum_clear", sum_out_big, 32'd0);
               checkOutput("ovf_clear", 32'(ovf_big), 32'd0);
               checkOutput("count_clear_small", 32'(count_small), 32'd0);
               checkOutput("ovf_clear_small", 32'(ovf_small), 32'd0);
            end else begin
               checkOutput("sum_out", sum_out_big, e_sum);
               checkOutput("sum_out_small", sum_out_small, e_sum);
               if (e_done) begin
                  checkOutput("count_out", count_big, 32'(m_raw));
                  checkOutput("overflow", 32'(ovf_big), 32'd0);
                  checkOutput("count_small", 32'(count_small), 32'(e_cnt_small));
                  checkOutput("ovf_small", 32'(ovf_small), 32'(m_raw > SMALL_MAX));
               end
            end
         end
      end
   end

   // Counts cycles with the ring enabled during the current run.
   initial begin
      ring_hi = 0;
      forever begin
         @(negedge wb_clk_i);
         if (ring_en_big) ring_hi++;
      end
   end

   // Drives a start for one cycle from the current negedge; returns at the
   // negedge of relative cycle 1.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int w);
      a_in = a;
      b_in = b;
      window = WINDOW_W'(w);
      start = 1'b1;
      ring_hi = 0;
      @(negedge wb_clk_i);
      start = 1'b0;
   endtask

   // Waits (bounded) for done; rel0 is the relative cycle on entry.
   task automatic wait_done(input int rel0, output int rel_out);
      int rel;
      rel = rel0;
      while (!done_big && rel < 300) begin
         @(negedge wb_clk_i);
         rel++;
      end
      checkOutput("done_seen", 32'(done_big), 32'd1);
      rel_out = rel;
   endtask

   // Watchdog in case the bench itself stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      vectors = 0;
      miscompares = 0;
      wb_rst_i = 1'b1;
      start = 1'b1;
      a_in = 32'hAAAA_5555;
      b_in = 32'h1234_5678;
      window = 16'd5;

      // Reset held two cycles with start high: start must be ignored.
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checkOutput("rst_busy", 32'(busy_big), 32'd0);
      checkOutput("rst_done", 32'(done_big), 32'd0);
      checkOutput("rst_a_out", a_out_big, 32'd0);
      checkOutput("rst_count", count_big, 32'd0);
      wb_rst_i = 1'b0;
      start = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("post_rst_busy", 32'(busy_big), 32'd0);

      // Basic run; the 3-bit instance saturates on the same run.
      applyStimulus(32'h0000_0003, 32'h0000_0005, 60);
      wait_done(1, n);
      checkOutput("basic_latency", 32'(n), 32'd69);
      checkOutput("basic_count", count_big, 32'd10);
      checkOutput("basic_sum", sum_out_big, 32'h0000_0008);
      checkOutput("basic_ovf", 32'(ovf_big), 32'd0);
      checkOutput("basic_ring_cycles", 32'(ring_hi), 32'd60);
      checkOutput("sat_count", 32'(count_small), 32'd7);
      checkOutput("sat_ovf", 32'(ovf_small), 32'd1);

      // Back-to-back start in the DONE cycle; sum carry is discarded.
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 6);
      checkOutput("b2b_done_drop", 32'(done_big), 32'd0);
      checkOutput("b2b_busy", 32'(busy_big), 32'd1);
      wait_done(1, n);
      checkOutput("b2b_latency", 32'(n), 32'd15);
      checkOutput("b2b_sum", sum_out_big, 32'h0000_0000);
      checkOutput("b2b_count", count_big, 32'd1);
      checkOutput("b2b_count_small", 32'(count_small), 32'd1);
      checkOutput("b2b_ovf_small", 32'(ovf_small), 32'd0);

      // Zero window: ring never enabled.
      applyStimulus(32'd7, 32'd9, 0);
      wait_done(1, n);
      checkOutput("zero_latency", 32'(n), 32'd9);
      checkOutput("zero_count", count_big, 32'd0);
      checkOutput("zero_ring_cycles", 32'(ring_hi), 32'd0);
      checkOutput("zero_sum", sum_out_big, 32'd16);

      // Start pulsed during MEASURE with different operands is ignored.
      applyStimulus(32'h0000_0010, 32'h0000_0020, 20);
      repeat (11) @(negedge wb_clk_i);
      a_in = 32'hDEAD_0000;
      b_in = 32'h0000_BEEF;
      window = 16'd2;
      start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
      wait_done(13, n);
      checkOutput("busy_start_latency", 32'(n), 32'd29);
      checkOutput("busy_start_a", a_out_big, 32'h0000_0010);
      checkOutput("busy_start_b", b_out_big, 32'h0000_0020);
      checkOutput("busy_start_count", count_big, 32'd3);
      checkOutput("busy_start_sum", sum_out_big, 32'h0000_0030);

      // Reset at MEASURE cycle 10 aborts the run.
      applyStimulus(32'd1, 32'd2, 30);
      repeat (14) @(negedge wb_clk_i);
      checkOutput("mid_ring_on", 32'(ring_en_big), 32'd1);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      checkOutput("mid_rst_ring", 32'(ring_en_big), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy_big), 32'd0);
      checkOutput("mid_rst_done", 32'(done_big), 32'd0);
      checkOutput("mid_rst_count", count_big, 32'd0);
      wb_rst_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);

      // A short run after the abort recovers normally.
      applyStimulus(32'h0000_0100, 32'h0000_0200, 4);
      wait_done(1, n);
      checkOutput("recover_latency", 32'(n), 32'd13);
      checkOutput("recover_count", count_big, 32'd1);
      checkOutput("recover_sum", sum_out_big, 32'h0000_0300);
      repeat (4) @(negedge wb_clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
